// File: rtl/rng_stream_arbiter_pkg.sv
// Shared types and defaults for the random-block stream arbiter.
package rng_pkg;
  localparam int WORD_W_DEF    = 32;
  localparam int NUM_WORDS_DEF = 128;

  typedef enum logic [2:0] {IDLE, TRIG, WAIT, STREAM, DONE} state_e;

  // Index width that stays legal for a single-entry vector.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/rng_stream_arbiter_if.sv
// Requester / generator / stream bundle of the arbiter.
// master = arbiter side, slave = surrounding environment.
interface rng_stream_arbiter_if
  import rng_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int WORD_W  = WORD_W_DEF
);
  logic [NUM_REQ-1:0] req_in;
  logic [NUM_REQ-1:0] grant_out;
  logic               gen_trigger_out;
  logic [WORD_W-1:0]  gen_data_in;
  logic               gen_valid_in;
  logic [WORD_W-1:0]  data_out;
  logic               valid_out;
  logic               last_out;
  logic [NUM_REQ-1:0] done_out;
  logic               error_out;

  modport master (
    input  req_in, gen_data_in, gen_valid_in,
    output grant_out, gen_trigger_out, data_out, valid_out, last_out,
           done_out, error_out
  );
  modport slave (
    output req_in, gen_data_in, gen_valid_in,
    input  grant_out, gen_trigger_out, data_out, valid_out, last_out,
           done_out, error_out
  );
endinterface

// File: rtl/rng_stream_arbiter_rr_select.sv
// Combinational round-robin pick: first set request at or after ptr_i.
module rr_select
  import rng_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int PTR_W   = idx_w(NUM_REQ)
)(
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [PTR_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] gnt_o
);
  logic [PTR_W-1:0] idx;
  logic             found;

  // Scan requesters starting at the pointer, wrapping around once.
  always_comb begin
    gnt_o = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = PTR_W'((int'(ptr_i) + k) % NUM_REQ);
      if (!found && req_i[idx]) begin
        gnt_o[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end
endmodule

// File: rtl/rng_stream_arbiter.sv
// Shares one random-block generator between NUM_REQ requesters and
// forwards each NUM_WORDS-word block to the current owner.
module rng_stream_arbiter
  import rng_pkg::*;
#(
  parameter int NUM_REQ       = 2,
  parameter int WORD_W        = WORD_W_DEF,
  parameter int NUM_WORDS     = NUM_WORDS_DEF,
  parameter int START_TIMEOUT = 4
)(
  input logic                 clk_in,
  input logic                 rst_n_in,
  rng_stream_arbiter_if.master bus
);
  localparam int CNT_W = $clog2(NUM_WORDS) + 1;
  localparam int PTR_W = idx_w(NUM_REQ);
  localparam int TMO_W = $clog2(START_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_WORDS - 1);

  logic [1:0]         rst_sync_q;
  logic               rst_n;
  state_e             state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d, rr_gnt;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [TMO_W-1:0]   tmo_q, tmo_d;
  logic [WORD_W-1:0]  data_q, data_d, word;
  logic               valid_q, valid_d, last_q, last_d, err_q, err_d, fwd;

  // Assert asynchronously, release only after two clean clk_in edges.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) rst_sync_q <= '0;
    else           rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_n = rst_sync_q[1];

  rr_select #(.NUM_REQ(NUM_REQ), .PTR_W(PTR_W)) u_rr (
    .req_i (bus.req_in),
    .ptr_i (ptr_q),
    .gnt_o (rr_gnt)
  );

  // State, ownership, pointer and the registered output stage.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      tmo_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      err_q   <= err_d;
    end
  end

  // Next-state logic; generator words are only accepted in WAIT/STREAM.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    tmo_d   = tmo_q;
    data_d  = data_q;
    valid_d = 1'b0;
    last_d  = 1'b0;
    err_d   = 1'b0;
    fwd     = 1'b0;
    // First word forced odd, last word forced full width.
    word = bus.gen_data_in;
    if (cnt_q == '0)      word[0]        = 1'b1;
    if (cnt_q == LAST_IDX) word[WORD_W-1] = 1'b1;
    case (state_q)
      IDLE: if (|bus.req_in) begin
        grant_d = rr_gnt;
        cnt_d   = '0;
        state_d = TRIG;
      end
      TRIG: begin
        tmo_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (bus.gen_valid_in) begin
          fwd     = 1'b1;
          state_d = STREAM;
        end else if (tmo_q == TMO_W'(START_TIMEOUT - 1)) begin
          err_d   = 1'b1;
          grant_d = '0;
          state_d = IDLE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      STREAM: begin
        if (bus.gen_valid_in) begin
          fwd = 1'b1;
        end else begin
          err_d   = 1'b1;
          grant_d = '0;
          state_d = IDLE;
        end
      end
      DONE: begin
        grant_d = '0;
        state_d = IDLE;
        // Priority moves past the requester that just completed.
        for (int k = 0; k < NUM_REQ; k++)
          if (grant_q[k]) ptr_d = PTR_W'((k + 1) % NUM_REQ);
      end
      default: state_d = IDLE;
    endcase
    // Count stops at the last word since the block leaves STREAM there.
    if (fwd) begin
      data_d  = word;
      valid_d = 1'b1;
      cnt_d   = cnt_q + 1'b1;
      if (cnt_q == LAST_IDX) begin
        last_d  = 1'b1;
        state_d = DONE;
      end
    end
  end

  assign bus.grant_out       = grant_q;
  assign bus.gen_trigger_out = (state_q == TRIG);
  assign bus.data_out        = data_q;
  assign bus.valid_out       = valid_q;
  assign bus.last_out        = last_q;
  assign bus.done_out        = (state_q == DONE) ? grant_q : '0;
  assign bus.error_out       = err_q;
endmodule

// File: doc/rng_stream_arbiter.md
RNG_STREAM_ARBITER -- requirements
Module: rng_stream_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 2, number of requesters sharing the random-block generator.
REQ-002 SHALL have parameter WORD_W, default 32, generator word width.
REQ-003 SHALL have parameter NUM_WORDS, default 128, words per 4096-bit random block.
REQ-004 SHALL have parameter START_TIMEOUT, default 4, maximum cycles from trigger to first generator word.
REQ-005 SHALL have port clk_in, input, 1, the single clock.
REQ-006 SHALL have port rst_n_in, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port req_in, input, NUM_REQ, level request per requester.
REQ-008 SHALL have port grant_out, output, NUM_REQ, one-hot owner of the current block; zero when idle.
REQ-009 SHALL have port gen_trigger_out, output, 1, single-cycle start pulse to the generator.
REQ-010 SHALL have port gen_data_in, input, WORD_W, generator word.
REQ-011 SHALL have port gen_valid_in, input, 1, generator word valid.
REQ-012 SHALL have port data_out, output, WORD_W, forwarded word.
REQ-013 SHALL have port valid_out, output, 1, data_out valid.
REQ-014 SHALL have port last_out, output, 1, marks word NUM_WORDS-1.
REQ-015 SHALL have port done_out, output, NUM_REQ, one-cycle completion pulse to the owner.
REQ-016 SHALL have port error_out, output, 1, one-cycle pulse on an aborted block.

Function
REQ-017 SHALL implement states IDLE, TRIG, WAIT, STREAM, DONE.
REQ-018 IDLE: with any req_in bit set, SHALL grant one requester round-robin, starting from the index after the last grantee, and go to TRIG.
REQ-019 TRIG SHALL assert gen_trigger_out for exactly one cycle, then go to WAIT.
REQ-020 WAIT SHALL go to STREAM on the first gen_valid_in, and SHALL count that word.
REQ-021 If no gen_valid_in is seen within START_TIMEOUT cycles of entering WAIT, WAIT SHALL pulse error_out and return to IDLE.
REQ-022 STREAM SHALL register each gen_data_in word into data_out with valid_out, giving 1-cycle latency.
REQ-023 Word count SHALL be $clog2(NUM_WORDS)+1 bits wide, SHALL be cleared on grant and SHALL never wrap.
REQ-024 Word 0 SHALL be forwarded with bit 0 forced to 1, so the block is odd.
REQ-025 Word NUM_WORDS-1 SHALL be forwarded with bit WORD_W-1 forced to 1, so the block has full width.
REQ-026 last_out SHALL be asserted together with valid_out for word NUM_WORDS-1 only.
REQ-027 If gen_valid_in deasserts in STREAM before NUM_WORDS words, the block SHALL pulse error_out, emit no last_out, drop grant_out and return to IDLE.
REQ-028 After the last word, DONE SHALL pulse done_out at the grantee index for one cycle, clear grant_out and return to IDLE.
REQ-029 grant_out SHALL be held constant from grant through DONE; req_in changes during a block SHALL be ignored.
REQ-030 gen_valid_in in IDLE, TRIG or DONE SHALL be ignored and SHALL never reach valid_out.
REQ-031 A new grant SHALL occur no earlier than the cycle after DONE.
REQ-032 The pointer SHALL advance only on successful completion; after an error the same requester keeps priority.

Reset
REQ-033 Asserting rst_n_in low SHALL immediately force state IDLE, grant_out=0, gen_trigger_out=0, data_out=0, valid_out=0, last_out=0, done_out=0, error_out=0, word count 0 and round-robin pointer 0.
REQ-034 Reset mid-block SHALL abort it with no done_out or error_out pulse.
REQ-035 Reset deassertion SHALL be synchronised to clk_in before reaching the state register.

Structure
REQ-036 The state enum, default NUM_WORDS=128 and WORD_W=32 SHALL live in shared package rng_pkg.
REQ-037 Round-robin selection SHALL be the sub-module rr_select: req vector plus pointer in, one-hot grant out, combinational.

Verification
REQ-038 Single requester: req_in=01 with the generator giving 128 words of 0x00000000 -> one trigger, 128 valid_out, word0=0x00000001, word127=0x80000000, last_out on 128th, done_out=01.
REQ-039 Contention: req_in=11 held for two blocks -> grants 01 then 10, each a complete 128-word block.
REQ-040 Start timeout: generator silent after trigger with START_TIMEOUT=4 -> error_out pulses within 5 cycles of the trigger, no valid_out, grant_out=00; the next grant goes to the same requester.
REQ-041 Early drop: gen_valid_in low after word 50 -> error_out pulse, last_out never asserted, no done_out.
REQ-042 Reset at word 64: rst_n_in low -> all outputs 0 at once; after release, req_in=10 is granted first (pointer 0).
REQ-043 Spurious generator valid in IDLE -> valid_out stays 0.
